// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM, ALU/immediate decoder and retired-instruction counter for a multicycle RV32I datapath.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes in a TRAP state and expose illegal_instr.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
  ,output logic            illegal_instr
`endif
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  state_t state, next, bad_op_next;
  logic pc_w, ir_w, mem_w, reg_w, retire;
  logic [2:0] funct_alu;
`ifdef ILLEGAL_TRAP_EN
  assign bad_op_next   = TRAP;
  assign illegal_instr = state == TRAP;
`else
  assign bad_op_next = FETCH;
`endif
  // an instruction retires on the cycle its final state hands back to FETCH
  assign retire = state == MEMWB || state == ALUWB || state == BEQ || (state == MEMWRITE && mem_ready);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state   <= next;
      instret <= retire ? instret + 1'b1 : instret;
    end
  end
  always_comb begin
    next = state;
    case (state)
      FETCH:    next = mem_ready ? DECODE : FETCH;
      DECODE:   next = (op == OP_LW || op == OP_SW) ? MEMADR :
                       op == OP_R   ? EXECUTER :
                       op == OP_I   ? EXECUTEI :
                       op == OP_BEQ ? BEQ :
                       op == OP_JAL ? JAL : bad_op_next;
      MEMADR:   next = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: next = ALUWB;
      MEMWB, ALUWB, BEQ:       next = FETCH;
      TRAP:     next = TRAP;
      default:  next = FETCH;
    endcase
  end
  assign funct_alu = funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (state)
      FETCH: begin
        ir_w      = mem_ready;
        pc_w      = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
      end
      ALUWB:    reg_w = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_w       = zero;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
      end
      default: ;
    endcase
  end
  assign ImmSrc   = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
  // write enables are held off for as long as reset is asserted
  assign PCWrite  = reset_n & pc_w;
  assign IRWrite  = reset_n & ir_w;
  assign MemWrite = reset_n & mem_w;
  assign RegWrite = reset_n & reg_w;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle scripts (inputs + expected controls) built from the instruction timing rules and replayed against the DUT.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset_n, zero, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] instret;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif
  int n = 0;
  int fails = 0;
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        z;
    logic [15:0] exp;
    logic [3:0]  cnt;
  } step_t;
  step_t q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [3:0] model_cnt;
  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .instret(instret)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction
  function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic supported(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction
  task automatic push(input logic mr, z, pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                      input logic [2:0] alu, input logic rw);
    step_t s;
    s.op  = cur_op;
    s.f3  = cur_f3;
    s.f7  = cur_f7;
    s.mr  = mr;
    s.z   = z;
    s.exp = {pcw, adr, mw, irw, rs, sa, sb, alu, imm_of(cur_op), rw};
    s.cnt = model_cnt;
    q.push_back(s);
  endtask
  // cls: 0 R, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 jal, 6 unsupported
  task automatic gen(input int cls, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int fw, input int mwt);
    cur_op = o;
    cur_f3 = f3;
    cur_f7 = f7;
    repeat (fw) push(1'b0, rb(), 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    push(1'b1, rb(), 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    case (cls)
      0, 1: begin
        push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b10, cls == 0 ? 2'b00 : 2'b01, alu_of(cls == 0, f3, f7), 0);
        push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
      end
      2: begin
        push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        repeat (mwt) push(1'b0, rb(), 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        push(1'b1, rb(), 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        push(rb(), rb(), 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1);
      end
      3: begin
        push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        repeat (mwt) push(1'b0, rb(), 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        push(1'b1, rb(), 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      end
      4: push(rb(), z, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
      5: begin
        push(rb(), rb(), 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
        push(rb(), rb(), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
      end
      default: ;
    endcase
    if (cls != 6) model_cnt = model_cnt + 4'd1;
  endtask
  task automatic run(input int max_steps);
    step_t s;
    int k = 0;
    while (q.size() > 0 && k < max_steps) begin
      s = q.pop_front();
      k++;
      @(negedge clk);
      op = s.op;
      funct3 = s.f3;
      funct7b5 = s.f7;
      mem_ready = s.mr;
      zero = s.z;
      #1;
      n++;
      assert ({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite} === s.exp)
        else begin
          fails++;
          $error("FAIL ctrl op=%b obs=%h exp=%h", s.op,
                 {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite}, s.exp);
        end
      n++;
      assert (instret === s.cnt) else begin
        fails++;
        $error("FAIL instret obs=%0d exp=%0d", instret, s.cnt);
      end
    end
    q.delete();
  endtask
  task automatic do_reset(input int cyc);
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    op = 7'b1101111;
    repeat (cyc) begin
      #1;
      n++;
      assert ({PCWrite, IRWrite, MemWrite, RegWrite} === 4'b0000) else begin
        fails++;
        $error("FAIL reset_we obs=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
      end
      n++;
      assert (instret === 4'd0) else begin
        fails++;
        $error("FAIL reset_cnt obs=%0d exp=0", instret);
      end
`ifdef ILLEGAL_TRAP_EN
      n++;
      assert (illegal_instr === 1'b0) else begin
        fails++;
        $error("FAIL reset_illegal obs=%b exp=0", illegal_instr);
      end
`endif
      @(negedge clk);
    end
    reset_n = 1'b1;
    mem_ready = 1'b0;
    q.delete();
    model_cnt = 4'd0;
  endtask
  initial begin
    logic [6:0] bad;
    int cls;
    reset_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    model_cnt = 4'd0;
    do_reset(3);
    gen(0, 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    gen(0, 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    gen(1, 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    gen(2, 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);
    gen(3, 7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1);
    gen(4, 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    gen(4, 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    gen(5, 7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    gen(0, 7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    gen(0, 7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
    gen(1, 7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    gen(6, 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
`endif
    run(10000);
    gen(2, 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    run(4);
    do_reset(1);
    for (int i = 0; i < 150; i++) begin
`ifdef ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 5);
`else
      cls = $urandom_range(0, 6);
`endif
      do bad = 7'($urandom); while (supported(bad));
      gen(cls, cls == 0 ? 7'b0110011 : cls == 1 ? 7'b0010011 : cls == 2 ? 7'b0000011 :
               cls == 3 ? 7'b0100011 : cls == 4 ? 7'b1100011 : cls == 5 ? 7'b1101111 : bad,
          3'($urandom), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run(100000);
`ifdef ILLEGAL_TRAP_EN
    gen(6, 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    run(100);
    repeat (10) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n++;
      assert (illegal_instr === 1'b1 && {PCWrite, IRWrite, MemWrite, RegWrite} === 4'b0000) else begin
        fails++;
        $error("FAIL trap obs=%b/%b exp=1/0000", illegal_instr, {PCWrite, IRWrite, MemWrite, RegWrite});
      end
    end
    do_reset(1);
    gen(0, 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run(100);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
